// File: rtl/hazard_sched.sv
// hazard_sched: in-order pipeline hazard scheduler.
// Handles three cases:
//   - A taken branch flushes IF/ID.
//   - A load-use hazard inserts a single bubble.
//   - A multi-cycle multiply holds ID/EX and stalls the front end
//     for MUL_LAT-1 cycles.
// Optional stall-cycle counter and its stall_cnt_o port are built
// only when HAZARD_STALL_CNT_EN is defined.
module hazard_sched #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_use_rs2_i,
  input  logic        id_mul_i,
  input  logic        branch_taken_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        idex_hold_o,
  output logic        mul_busy_o
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  // The multiply spends one cycle in RUN and the rest in MUL_WAIT.
  // The counter therefore starts at MUL_LAT-2 and exits after reaching zero.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);

  state_t     state;
  logic [3:0] mul_cnt;
  logic       lu;

  // Load-use hazard: the load in EX writes a register that the ID instruction reads.
  assign lu = ex_memread_i && (ex_rd_addr_i != '0) &&
              ((ex_rd_addr_i == id_rs1_addr_i) ||
               (id_use_rs2_i && (ex_rd_addr_i == id_rs2_addr_i)));

  // Pipeline control decode.
  // Reset is gated in so that reset values hold even while inputs toggle.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    idex_hold_o   = 1'b0;
    mul_busy_o    = 1'b0;
    if (!rst_i) begin
      case (state)
        RUN: begin
          if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
          end else if (lu) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
          end
        end
        MUL_WAIT: begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          idex_hold_o  = 1'b1;
          mul_busy_o   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM state and multiply down-counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!branch_taken_i && !lu && id_mul_i) begin
            state   <= MUL_WAIT;
            mul_cnt <= MUL_CNT_INIT;
          end
        end
        MUL_WAIT: begin
          if (mul_cnt == '0) begin
            state <= RUN;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic        stall_cyc;

  // Count load-use bubble cycles and multiply-wait cycles.
  // Branch flushes are not counted.
  assign stall_cyc = ((state == RUN) && !branch_taken_i && lu) ||
                     (state == MUL_WAIT);

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall_cyc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

endmodule
